arr_mult_seq: RTL

- Sequential controller that computes an unsigned DATA_W x DATA_W product by time-sharing a single 4x4 array-multiplier core.
- Each cycle it multiplies one operand nibble pair, shifts the result and adds it into an accumulator.
- Uses a valid/ready handshake on both input and output, so the multiplier can sit on a pipelined bus or behind an arbiter.
- Trades latency for area versus a full DATA_W array multiplier.

---
 rtl/arr_mult_pkg.sv | 16 +
 rtl/nib_mul4.sv | 39 +++
 rtl/arr_mult_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/arr_mult_pkg.sv
// rtl/arr_mult_pkg.sv - shared constants and state encoding for arr_mult_seq
package arr_mult_pkg;

    localparam int NIB_W = 4;

    // Index counters are sized for the widest legal operand (16 bits = 4 nibbles).
    localparam int MAX_NCHUNK = 4;
    localparam int IDX_W = $clog2(MAX_NCHUNK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nib_mul4.sv
// rtl/nib_mul4.sv - combinational 4x4 unsigned array multiplier, 8-bit product
module nib_mul4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [4:0] sum;
    logic [4:0] nxt;
    logic       cy;
    logic       x;
    logic       y;

    // Row r adds the partial product a & b[r] into the upper bits of the running
    // row sum through a 4-bit ripple chain; the low bit of each row retires.
    always_comb begin
        sum  = {1'b0, a & {4{b[0]}}};
        nxt  = '0;
        cy   = 1'b0;
        x    = 1'b0;
        y    = 1'b0;
        p    = '0;
        p[0] = sum[0];
        for (int r = 1; r < 4; r++) begin
            cy = 1'b0;
            for (int c = 0; c < 4; c++) begin
                x      = sum[c + 1];
                y      = a[c] & b[r];
                nxt[c] = x ^ y ^ cy;
                cy     = (x & y) | (cy & (x ^ y));
            end
            nxt[4] = cy;
            sum    = nxt;
            p[r]   = sum[0];
        end
        p[7:4] = sum[4:1];
    end

endmodule

// File: rtl/arr_mult_seq.sv
// rtl/arr_mult_seq.sv - sequential DATA_W x DATA_W multiplier on one 4x4 core; ARR_MULT_SEQ_ZERO_SKIP_EN skips CALC for zero operands
module arr_mult_seq
    import arr_mult_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   result,
    output logic                  busy
);

    localparam int NCHUNK = DATA_W / NIB_W;
    localparam int ACC_W  = 2 * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t               state;
    logic [DATA_W-1:0]    aReg;
    logic [DATA_W-1:0]    bReg;
    logic [ACC_W-1:0]     acc;
    logic [IDX_W-1:0]     iIdx;
    logic [IDX_W-1:0]     jIdx;

    logic [NIB_W-1:0]     aNib;
    logic [NIB_W-1:0]     bNib;
    logic [2*NIB_W-1:0]   pp;
    logic [IDX_W:0]       posSum;
    logic [ACC_W-1:0]     ppShifted;

    always_comb begin
        aNib = '0;
        bNib = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (iIdx == IDX_W'(k)) aNib = aReg[k*NIB_W +: NIB_W];
            if (jIdx == IDX_W'(k)) bNib = bReg[k*NIB_W +: NIB_W];
        end
    end

    nib_mul4 u_nib_mul4 (
        .a (aNib),
        .b (bNib),
        .p (pp)
    );

    // Nibble position i+j scaled by 4 gives the bit offset of this partial product.
    assign posSum    = {1'b0, iIdx} + {1'b0, jIdx};
    assign ppShifted = ACC_W'(pp) << {posSum, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            iIdx  <= '0;
            jIdx  <= '0;
            aReg  <= '0;
            bReg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        aReg <= a;
                        bReg <= b;
                        acc  <= '0;
                        iIdx <= '0;
                        jIdx <= '0;
`ifdef ARR_MULT_SEQ_ZERO_SKIP_EN
                        state <= (a == '0 || b == '0) ? ST_DONE : ST_CALC;
`else
                        state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    acc <= acc + ppShifted;
                    if (jIdx == LAST_IDX) begin
                        jIdx <= '0;
                        if (iIdx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            iIdx <= iIdx + 1'b1;
                        end
                    end else begin
                        jIdx <= jIdx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_CALC) || (state == ST_DONE);
    assign result    = acc;

endmodule
